// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative set-less-than unit: FSM states and
// slice-count / index-width helpers.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  function automatic int unsigned num_slices(input int unsigned width,
                                             input int unsigned slice);
    return (slice == 0) ? 1 : width / slice;
  endfunction

  function automatic int unsigned idx_width(input int unsigned ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Unsigned comparison of one operand slice: less-than and not-equal flags.
module slice_cmp #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             ne
);

  assign lt = (a < b);
  assign ne = (a != b);

endmodule

// File: rtl/iter_slt_unit.sv
// Multi-cycle signed/unsigned set-less-than: walks the operands MSB slice
// first, one slice per clock, with optional exit on the first difference.
module iter_slt_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SLICE      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq
);
  import cmp_pkg::*;

  localparam int unsigned NS = num_slices(WIDTH, SLICE);
  localparam int unsigned IW = idx_width(NS);

  if (SLICE == 0) begin : g_bad_slice
    $error("iter_slt_unit: SLICE must be nonzero");
  end else if (WIDTH % SLICE != 0) begin : g_bad_div
    $error("iter_slt_unit: SLICE must divide WIDTH");
  end

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             diff_seen, lt_rec;
  logic             lt_q, eq_q;
  logic [SLICE-1:0] sa, sb;
  logic             s_lt, s_ne;
  logic             fin_lt, fin_diff;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
  end

  slice_cmp #(.SLICE(SLICE)) u_slice (
    .a  (sa),
    .b  (sb),
    .lt (s_lt),
    .ne (s_ne)
  );

  // The first differing slice (most significant) decides the order.
  assign fin_diff = diff_seen | s_ne;
  assign fin_lt   = diff_seen ? lt_rec : (s_ne & s_lt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = CMP;
      CMP: begin
        if ((EARLY_EXIT && s_ne) || (idx == '0)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CMP);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      diff_seen <= 1'b0;
      lt_rec    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q       <= A ^ {is_signed, {(WIDTH-1){1'b0}}};
            b_q       <= B ^ {is_signed, {(WIDTH-1){1'b0}}};
            idx       <= IW'(NS-1);
            diff_seen <= 1'b0;
            lt_rec    <= 1'b0;
          end
        end
        CMP: begin
          if (s_ne && !diff_seen) begin
            diff_seen <= 1'b1;
            lt_rec    <= s_lt;
          end
          if (state_nx == DONE) begin
            lt_q <= fin_lt;
            eq_q <= ~fin_diff;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lt     = lt_q;
  assign eq     = eq_q;
  assign result = {{(WIDTH-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_iter_slt_unit.sv
// Self-checking bench for iter_slt_unit: three configurations (early exit,
// fixed latency, single slice) checked against vectors and a reference model.
module tb_iter_slt_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_signed = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, lt_v, eq_v;
  logic [31:0] res_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_slt_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .is_signed(is_signed), .A(A), .B(B),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .lt(lt_v[0]), .eq(eq_v[0]));

  iter_slt_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .is_signed(is_signed), .A(A), .B(B),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .lt(lt_v[1]), .eq(eq_v[1]));

  iter_slt_unit #(.WIDTH(32), .SLICE(32), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .is_signed(is_signed), .A(A), .B(B),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .lt(lt_v[2]), .eq(eq_v[2]));

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    bit          elt;
    bit          eeq;
    int          elat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: order from plain signed/unsigned arithmetic; latency from the
  // position of the most significant differing slice.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       input int w, output bit mlt, output bit meq, output int mlat);
    int ns = (w == 2) ? 1 : 4;
    bit ee = (w != 1);
    int sw = 32 / ns;
    int first = -1;
    longint unsigned m = (64'd1 << sw) - 1;
    longint unsigned x = 64'(a ^ b);
    mlt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    meq = (a == b);
    for (int k = ns - 1; k >= 0; k--)
      if (first < 0 && ((x >> (k * sw)) & m) != 0) first = k;
    mlat = (!ee || first < 0) ? ns + 1 : (ns - first) + 1;
  endtask

  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, output int lat);
    @(negedge clk);
    A = a; B = b; is_signed = sgn; start_v[w] = 1'b1;
    @(posedge clk);
    #1;
    start_v[w] = 1'b0;
    A = $urandom; B = $urandom; is_signed = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_v[w]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_check(input string tag, input int w, input logic [31:0] a,
                          input logic [31:0] b, input bit sgn, input bit elt,
                          input bit eeq, input int elat);
    int lat;
    run_op(w, a, b, sgn, lat);
    chk({tag, " latency"}, lat, elat);
    if (lat > 0) begin
      chk({tag, " lt"}, lt_v[w], elt);
      chk({tag, " eq"}, eq_v[w], eeq);
      chk({tag, " result"}, res_v[w], {31'd0, elt});
      chk({tag, " busy at done"}, busy_v[w], 0);
      @(negedge clk);
      chk({tag, " done one cycle"}, done_v[w], 0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, cnt;
    bit eqs;
    bit mlt, meq;
    int mlat;

    vecs = '{
      '{0, 32'h00000002, 32'h00000003, 1'b1, 1'b1, 1'b0, 5},
      '{0, 32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b1, 1'b0, 2},
      '{0, 32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0, 1'b0, 2},
      '{0, 32'hFFFFFFF6, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b0, 5},
      '{0, 32'hFFFFFF61, 32'h00000058, 1'b1, 1'b1, 1'b0, 2},
      '{0, 32'h0000006F, 32'h0000006F, 1'b0, 1'b0, 1'b1, 5},
      '{0, 32'h000003E4, 32'h0000029D, 1'b0, 1'b0, 1'b0, 4},
      '{0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 2},
      '{0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 2},
      '{1, 32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b1, 1'b0, 5},
      '{1, 32'hFFFFFF03, 32'h00000003, 1'b1, 1'b1, 1'b0, 5},
      '{1, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1, 5},
      '{2, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 2},
      '{2, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1'b1, 2},
      '{2, 32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0, 1'b0, 2}
    };

    // Reset state
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("reset busy%0d", w), busy_v[w], 0);
      chk($sformatf("reset done%0d", w), done_v[w], 0);
      chk($sformatf("reset lt%0d", w), lt_v[w], 0);
      chk($sformatf("reset eq%0d", w), eq_v[w], 0);
      chk($sformatf("reset result%0d", w), res_v[w], 0);
    end
    rst = 1'b0;

    foreach (vecs[i])
      do_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b,
               vecs[i].sgn, vecs[i].elt, vecs[i].eeq, vecs[i].elat);

    // Hold: results persist through IDLE and the next operation's CMP cycles
    do_check("hold first", 0, 32'h0000006F, 32'h0000006F, 1'b0, 1'b0, 1'b1, 5);
    chk("hold idle eq", eq_v[0], 1);
    @(negedge clk);
    A = 32'h000003E4; B = 32'h0000029D; is_signed = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold cmp%0d eq", k), eq_v[0], 1);
      chk($sformatf("hold cmp%0d lt", k), lt_v[0], 0);
      chk($sformatf("hold cmp%0d busy", k), busy_v[0], 1);
    end
    @(negedge clk);
    chk("hold second done", done_v[0], 1);
    chk("hold second eq", eq_v[0], 0);
    chk("hold second lt", lt_v[0], 0);

    // start pulsed while busy is ignored
    @(negedge clk);
    A = 32'h0000006F; B = 32'h0000006F; is_signed = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    cnt = 0; eqs = 1'b0; lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin A = 32'h1; B = 32'h2; end
      if (k == 4) start_v[0] = 1'b0;
      if (done_v[0]) begin
        cnt++;
        eqs = eq_v[0];
        if (lat < 0) lat = k;
      end
    end
    chk("busy start done count", cnt, 1);
    chk("busy start latency", lat, 5);
    chk("busy start eq", eqs, 1);

    // Reset in the second CMP cycle abandons the operation
    do_check("pre-reset", 0, 32'h00000002, 32'h00000003, 1'b1, 1'b1, 1'b0, 5);
    @(negedge clk);
    A = 32'hABCDEF01; B = 32'hABCDEF01; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", busy_v[0], 0);
    chk("rst done", done_v[0], 0);
    chk("rst lt", lt_v[0], 0);
    chk("rst eq", eq_v[0], 0);
    chk("rst result", res_v[0], 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_v[0]) cnt++;
    end
    chk("rst no done", cnt, 0);

    // Randomised operations against the reference model
    for (int i = 0; i < 300; i++) begin
      int w = i % 3;
      logic [31:0] a, b;
      bit sgn;
      a = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: b = {8'($urandom), a[23:0]};
      endcase
      model(a, b, sgn, w, mlt, meq, mlat);
      do_check($sformatf("rand%0d", i), w, a, b, sgn, mlt, meq, mlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
